// File: rtl/image_feed_ctrl.sv
// image_feed_ctrl
//   Feeds pixels from an upstream source into the image_top filter. After a
//   start pulse it primes the filter line buffers with PRIME_LINES lines.
//   After that it releases one image line per rising edge of the filter's INT.
//   The frame ends with PAD_LINES all-zero lines so the filter can flush its
//   last output rows.
//   Optional build macro: FEED_TIMEOUT_EN adds a watchdog on the INT waits.
//   When the watchdog expires it aborts the frame and raises the sticky err.
module image_feed_ctrl #(
  parameter int IMG_W       = 512,
  parameter int IMG_H       = 512,
  parameter int PRIME_LINES = 4,
  parameter int PAD_LINES   = 2,
  parameter int DW          = 8,
  parameter int TO_CYCLES   = 65535
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          start,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          TVALID_man,
  output logic [DW-1:0] TDATA_man,
  input  logic          TREADY_man,
  input  logic          INT,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LW = $clog2(IMG_H + 1);
  localparam int PW = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [LW-1:0] PRIME_LAST = LW'(PRIME_LINES - 1);
  localparam logic [LW-1:0] IMG_LAST   = LW'(IMG_H - 1);
  localparam logic [PW-1:0] PAD_LAST   = PW'((PAD_LINES > 0) ? PAD_LINES - 1 : 0);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRIME    = 3'd1;
  localparam logic [2:0] ST_WAIT_INT = 3'd2;
  localparam logic [2:0] ST_LINE     = 3'd3;
  localparam logic [2:0] ST_PAD_WAIT = 3'd4;
  localparam logic [2:0] ST_PAD      = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  // With no pad lines configured, the frame finishes directly after the image.
  localparam logic [2:0] ST_AFTER_IMAGE = (PAD_LINES > 0) ? ST_PAD_WAIT : ST_DONE;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [LW-1:0] line_q, line_d;
  logic [PW-1:0] pad_q, pad_d;
  logic [1:0]    credit_q, credit_d;
  logic          int_q;
  logic          busy_q, busy_d;

  logic feed_st;
  logic pad_st;
  logic wait_st;
  logic xfer;
  logic line_end;
  logic int_rise;
  logic consume;
  logic timeout;

  assign feed_st  = (state_q == ST_PRIME) || (state_q == ST_LINE);
  assign pad_st   = (state_q == ST_PAD);
  assign wait_st  = (state_q == ST_WAIT_INT) || (state_q == ST_PAD_WAIT);
  assign xfer     = TVALID_man & TREADY_man;
  assign line_end = xfer && (col_q == COL_LAST);
  assign int_rise = INT & ~int_q;
  assign consume  = wait_st && (credit_q != 2'd0);

  // Stream muxing: zero-latency pass-through while feeding, constant zeros while padding.
  always_comb begin
    src_ready  = 1'b0;
    TVALID_man = 1'b0;
    TDATA_man  = '0;
    if (feed_st) begin
      TVALID_man = src_valid;
      TDATA_man  = src_data;
      src_ready  = TREADY_man;
    end else if (pad_st) begin
      TVALID_man = 1'b1;
    end
  end

  // Frame sequencing and the column, image-line and pad-line counters.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    pad_d   = pad_q;

    if (xfer) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PRIME;
          col_d   = '0;
          line_d  = '0;
          pad_d   = '0;
        end
      end
      ST_PRIME: begin
        if (line_end) begin
          line_d = line_q + LW'(1);
          if (line_q == PRIME_LAST) begin
            state_d = (IMG_H == PRIME_LINES) ? ST_AFTER_IMAGE : ST_WAIT_INT;
          end
        end
      end
      ST_WAIT_INT: begin
        if (consume) begin
          state_d = ST_LINE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_LINE: begin
        if (line_end) begin
          line_d  = line_q + LW'(1);
          state_d = (line_q == IMG_LAST) ? ST_AFTER_IMAGE : ST_WAIT_INT;
        end
      end
      ST_PAD_WAIT: begin
        if (consume) begin
          state_d = ST_PAD;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAD: begin
        if (line_end) begin
          pad_d   = pad_q + PW'(1);
          state_d = (pad_q == PAD_LAST) ? ST_DONE : ST_PAD_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // INT credit pool: rises add and waits consume; a rise coinciding with a consume cancels out.
  always_comb begin
    credit_d = credit_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        credit_d = 2'd0;
      end
    end else begin
      case ({int_rise, consume})
        2'b10:   credit_d = (credit_q == 2'd3) ? credit_q : credit_q + 2'd1;
        2'b01:   credit_d = credit_q - 2'd1;
        default: credit_d = credit_q;
      endcase
    end
  end

  // busy follows the registered state so it rises the cycle after start is accepted.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
  end

  // Core state registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      line_q   <= '0;
      pad_q    <= '0;
      credit_q <= 2'd0;
      int_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      line_q   <= line_d;
      pad_q    <= pad_d;
      credit_q <= credit_d;
      int_q    <= INT;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = (state_q == ST_DONE);

`ifdef FEED_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);

  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;

  assign timeout = wait_st && (credit_q == 2'd0) && (to_q == TO_LAST);

  // Watchdog counts the cycles spent in the current wait state.
  // Leaving the wait state, including a short detour through LINE or PAD, restarts it at zero.
  always_comb begin
    to_d  = '0;
    err_d = err_q;
    if (wait_st && (state_d == state_q)) begin
      to_d = to_q + TW'(1);
    end
    if ((state_q == ST_IDLE) && start) begin
      err_d = 1'b0;
    end
    if (timeout) begin
      err_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_image_feed_ctrl.sv
// Testbench for image_feed_ctrl (IMG_W=4, IMG_H=6, PRIME_LINES=4, PAD_LINES=2).
// The reference model is the expected transfer stream: the source pixels in
// the order they are offered, followed by PAD_LINES*IMG_W zeros. A line-budget
// bound also applies: at most PRIME_LINES plus the number of INT rises seen
// while busy.
module tb_image_feed_ctrl;

  localparam int W     = 4;
  localparam int H     = 6;
  localparam int PL    = 4;
  localparam int PD    = 2;
  localparam int DW    = 8;
  localparam int TO    = 10;
  localparam int TOTAL = W * (H + PD);

  logic          ACLK;
  logic          ARESET;
  logic          start;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          TVALID_man;
  logic [DW-1:0] TDATA_man;
  logic          TREADY_man;
  logic          INT;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] src_mem [0:63];
  logic [DW-1:0] got[$];
  int   src_idx;
  int   done_cnt;
  int   rises;
  int   bound_viol;
  logic int_prev;
  logic busy_last;
  logic done_last;

  image_feed_ctrl #(
    .IMG_W      (W),
    .IMG_H      (H),
    .PRIME_LINES(PL),
    .PAD_LINES  (PD),
    .DW         (DW),
    .TO_CYCLES  (TO)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .start     (start),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .TVALID_man(TVALID_man),
    .TDATA_man (TDATA_man),
    .TREADY_man(TREADY_man),
    .INT       (INT),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Reference stream: image pixels in source order, then zero pad lines.
  function automatic logic [DW-1:0] exp_pix(input int i);
    if (i < W * H) return src_mem[i];
    return '0;
  endfunction

  task automatic fill_src(input bit ramp);
    for (int i = 0; i < 64; i++) begin
      src_mem[i] = ramp ? DW'(i) : DW'($urandom_range(1, 255));
    end
  endtask

  // One clock: drive inputs just after the rising edge, observe at the falling edge.
  task automatic step(input logic st, input logic v, input logic rdy, input logic intr);
    @(posedge ACLK);
    #1;
    start      = st;
    src_valid  = v;
    src_data   = src_mem[src_idx];
    TREADY_man = rdy;
    INT        = intr;
    @(negedge ACLK);
    if (TVALID_man && TREADY_man) got.push_back(TDATA_man);
    if (src_valid && src_ready && src_idx < 63) src_idx++;
    if (done) done_cnt++;
    if (intr && !int_prev && busy) rises++;
    int_prev  = intr;
    busy_last = busy;
    done_last = done;
    if (got.size() > W * (PL + rises)) bound_viol++;
  endtask

  task automatic clear_model();
    got.delete();
    src_idx    = 0;
    done_cnt   = 0;
    rises      = 0;
    bound_viol = 0;
  endtask

  task automatic do_reset();
    ARESET     = 1'b1;
    start      = 1'b0;
    src_valid  = 1'b0;
    TREADY_man = 1'b0;
    INT        = 1'b0;
    int_prev   = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    clear_model();
  endtask

  // Run the rest of a frame with periodic INT pulses until done, bounded.
  task automatic finish_frame(input bit rnd);
    logic v, r, ip, st;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      r  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ip = ((k % 6) < 2);
      st = rnd && busy_last && !done_last && ($urandom_range(0, 9) == 0);
      step(st, v, r, ip);
    end
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    ARESET     = 1'b1;
    start      = 1'b0;
    src_valid  = 1'b1;
    src_data   = 8'hA5;
    TREADY_man = 1'b1;
    INT        = 1'b0;
    int_prev   = 1'b0;
    clear_model();
    repeat (2) @(negedge ACLK);
    n_checks++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready got=%b exp=0", src_ready); end
    n_checks++; if (TVALID_man !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", TVALID_man); end
    n_checks++; if (TDATA_man !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got=%h exp=00", TDATA_man); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (TVALID_man !== 1'b0 || src_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_outputs tvalid=%b src_ready=%b exp=0/0", TVALID_man, src_ready);
    end
  endtask

  task automatic test_prime_ramp();
    do_reset();
    fill_src(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL prime_count got=%0d exp=16", got.size()); end
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL prime_hold got=%0d exp=16", got.size()); end
    n_checks++; if (TVALID_man !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wait_int_outputs tvalid=%b busy=%b exp=0/1", TVALID_man, busy);
    end
    for (int ln = 0; ln < 4; ln++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1);
      repeat (9) step(1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++; if (got.size() != 16 + 4 * (ln + 1)) begin
        n_fail++; $display("FAIL line_release_%0d got=%0d exp=%0d", ln, got.size(), 16 + 4 * (ln + 1));
      end
    end
    n_checks++; if (got.size() != TOTAL) begin n_fail++; $display("FAIL ramp_total got=%0d exp=%0d", got.size(), TOTAL); end
    for (int i = 0; i < got.size() && i < TOTAL; i++) begin
      n_checks++; if (got[i] !== exp_pix(i)) begin n_fail++; $display("FAIL ramp_pix[%0d] got=%h exp=%h", i, got[i], exp_pix(i)); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ramp_done_pulses got=%0d exp=1", done_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_end got=%b exp=0", busy); end
    n_checks++; if (src_idx != W * H) begin n_fail++; $display("FAIL ramp_src_taken got=%0d exp=%0d", src_idx, W * H); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ramp_err got=%b exp=0", err); end
    n_checks++; if (bound_viol != 0) begin n_fail++; $display("FAIL ramp_line_budget got=%0d exp=0", bound_viol); end
  endtask

  task automatic test_prime_credits();
    do_reset();
    fill_src(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b1, (k == 3 || k == 8));
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (got.size() != W * H) begin n_fail++; $display("FAIL credit_image_lines got=%0d exp=%0d", got.size(), W * H); end
    n_checks++; if (TVALID_man !== 1'b0 || done_cnt != 0) begin
      n_fail++; $display("FAIL credit_pad_wait tvalid=%b done=%0d exp=0/0", TVALID_man, done_cnt);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (9) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (got.size() != W * (H + 1)) begin n_fail++; $display("FAIL credit_pad1 got=%0d exp=%0d", got.size(), W * (H + 1)); end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (9) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (got.size() != TOTAL || done_cnt != 1) begin
      n_fail++; $display("FAIL credit_finish got=%0d/%0d exp=%0d/1", got.size(), done_cnt, TOTAL);
    end
    for (int i = 0; i < got.size() && i < TOTAL; i++) begin
      n_checks++; if (got[i] !== exp_pix(i)) begin n_fail++; $display("FAIL credit_pix[%0d] got=%h exp=%h", i, got[i], exp_pix(i)); end
    end
  endtask

  task automatic test_backpressure();
    int first_k;
    int last_k;
    logic r;
    do_reset();
    fill_src(1'b0);
    first_k = -1;
    last_k  = -1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      r = (k % 2 == 0);
      step(1'b0, 1'b1, r, 1'b0);
      if (TVALID_man) begin
        n_checks++; if (src_ready !== TREADY_man) begin
          n_fail++; $display("FAIL bp_src_ready k=%0d got=%b exp=%b", k, src_ready, TREADY_man);
        end
      end
      if (got.size() == 17 && first_k < 0) first_k = k;
      if (got.size() == 20 && last_k < 0) last_k = k;
    end
    n_checks++; if (last_k - first_k != 6) begin n_fail++; $display("FAIL bp_line_span got=%0d exp=6", last_k - first_k); end
    n_checks++; if (got.size() != 20) begin n_fail++; $display("FAIL bp_line_count got=%0d exp=20", got.size()); end
    finish_frame(1'b1);
    n_checks++; if (got.size() != TOTAL || done_cnt != 1) begin
      n_fail++; $display("FAIL bp_finish got=%0d/%0d exp=%0d/1", got.size(), done_cnt, TOTAL);
    end
    for (int i = 0; i < got.size() && i < TOTAL; i++) begin
      n_checks++; if (got[i] !== exp_pix(i)) begin n_fail++; $display("FAIL bp_pix[%0d] got=%h exp=%h", i, got[i], exp_pix(i)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      fill_src(1'b0);
      clear_model();
      step(1'b1, 1'b1, 1'b1, 1'b0);
      finish_frame(1'b1);
      n_checks++; if (got.size() != TOTAL || done_cnt != 1) begin
        n_fail++; $display("FAIL b2b_frame%0d got=%0d/%0d exp=%0d/1", f, got.size(), done_cnt, TOTAL);
      end
      for (int i = 0; i < got.size() && i < TOTAL; i++) begin
        n_checks++; if (got[i] !== exp_pix(i)) begin
          n_fail++; $display("FAIL b2b_pix%0d[%0d] got=%h exp=%h", f, i, got[i], exp_pix(i));
        end
      end
      n_checks++; if (src_idx != W * H || bound_viol != 0) begin
        n_fail++; $display("FAIL b2b_src%0d taken=%0d viol=%0d exp=%0d/0", f, src_idx, bound_viol, W * H);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fill_src(1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 20 && got.size() < 18; k++) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (got.size() != 18) begin n_fail++; $display("FAIL arst_reach_col2 got=%0d exp=18", got.size()); end
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    #1;
    n_checks++; if (TVALID_man !== 1'b0 || src_ready !== 1'b0 || TDATA_man !== 8'h00) begin
      n_fail++; $display("FAIL arst_outputs tvalid=%b src_ready=%b tdata=%h exp=0/0/00", TVALID_man, src_ready, TDATA_man);
    end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL arst_status busy=%b done=%b exp=0/0", busy, done);
    end
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL arst_reprime_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      n_checks++; if (got[i] !== exp_pix(i)) begin n_fail++; $display("FAIL arst_reprime[%0d] got=%h exp=%h", i, got[i], exp_pix(i)); end
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL arst_no_done got=%0d exp=0", done_cnt); end
  endtask

`ifdef FEED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    do_reset();
    fill_src(1'b1);
    n = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      if (!busy) break;
      n++;
    end
    n_checks++; if (n != TO) begin n_fail++; $display("FAIL to_wait_cycles got=%0d exp=%0d", n, TO); end
    n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL to_abort err=%b busy=%b exp=1/0", err, busy);
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL to_no_done got=%0d exp=0", done_cnt); end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL to_restart err=%b busy=%b exp=0/1", err, busy);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL global_timeout sim_time=%0t limit=1000000", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    ARESET    = 1'b1;
    busy_last = 1'b0;
    done_last = 1'b0;
    src_idx   = 0;
    fill_src(1'b1);
    test_reset();
    test_prime_ramp();
    test_prime_credits();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
`ifdef FEED_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
